// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one 32-bit slave port between M_W masters.
// It supports bus lock and a bounded hold time, and it drives a registered
// one-hot grant. The slave-side datapath is a plain mux selected by the
// registered owner_id.
module rr_bus_arbiter #(
  parameter int M_W      = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(M_W)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [M_W-1:0]        bus_req,
  input  logic [M_W-1:0]        bus_lock,
  output logic [M_W-1:0]        bus_grant,
  input  logic [M_W-1:0][31:0]  addr_m,
  output logic [M_W-1:0][31:0]  rd_m,
  input  logic [M_W-1:0][31:0]  wd_m,
  input  logic [M_W-1:0]        we_m,
  input  logic [M_W-1:0][1:0]   size_m,
  output logic [31:0]           addr_f,
  input  logic [31:0]           rd_f,
  output logic [31:0]           wd_f,
  output logic                  we_f,
  output logic [1:0]            size_f,
  output logic [ID_W-1:0]       owner_id,
  output logic                  busy
);

  localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_SAT = HC_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [ID_W-1:0] last_owner;
  logic [HC_W-1:0] hold_cnt;

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic [M_W-1:0]  win_oh;
  logic            found;

  // Winner scan. While idle the scan starts after last_owner. While owned it
  // starts after the current owner and skips that owner, so a rotation always
  // moves to the next requester above the one giving up the bus. In OWNED,
  // 'found' therefore also means "another master is waiting".
  always_comb begin
    base   = busy ? owner_id : last_owner;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= M_W; k++) begin
      idx = ID_W'((int'(base) + k) % M_W);
      if (!found && bus_req[idx] && !(busy && (idx == owner_id))) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    win_oh = {{(M_W-1){1'b0}}, 1'b1} << winner;
  end

  // Arbitration FSM. Grant, owner, busy and the hold counter are all registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bus_grant  <= '0;
      owner_id   <= '0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= ID_W'(M_W - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= OWNED;
            bus_grant <= win_oh;
            owner_id  <= winner;
            busy      <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        OWNED: begin
          // Release when the owner drops its request. Preempt when the owner is
          // unlocked, its hold budget is used up and someone else is waiting.
          if (!bus_req[owner_id] ||
              (!bus_lock[owner_id] && (hold_cnt == HOLD_SAT) && found)) begin
            last_owner <= owner_id;
            hold_cnt   <= '0;
            if (found) begin
              bus_grant <= win_oh;
              owner_id  <= winner;
            end else begin
              state     <= IDLE;
              bus_grant <= '0;
              busy      <= 1'b0;
            end
          end else if (found && (hold_cnt != HOLD_SAT)) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-side mux. It is zeroed while idle, so no stray write can leak out.
  always_comb begin
    addr_f = busy ? addr_m[owner_id] : '0;
    wd_f   = busy ? wd_m[owner_id]   : '0;
    size_f = busy ? size_m[owner_id] : '0;
    we_f   = busy & we_m[owner_id];
  end

  // Read data fans out to every master. Each master qualifies it with its own
  // grant bit.
  for (genvar i = 0; i < M_W; i++) begin : g_rd
    assign rd_m[i] = rd_f;
  end

endmodule
